// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: FSM encoding, BCD time
// record, seven-segment pattern table and the digit arithmetic helpers.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } sw_state_e;

  // mm:ss as four BCD digits, most significant first
  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [3:0] sec_tens;
    logic [3:0] sec_units;
  } bcd_time_t;

  localparam logic [5:0] MAX_FIELD = 6'd59;

  // Active-low segment patterns, bit order a..g; entry 15 listed first
  localparam logic [15:0][0:6] SEG7_LUT = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  // Binary 0..63 to two BCD digits, clamping anything above 59
  function automatic logic [7:0] bin_to_bcd(input logic [5:0] v);
    logic [5:0] c;
    c = (v > MAX_FIELD) ? MAX_FIELD : v;
    return {4'(c / 6'd10), 4'(c % 6'd10)};
  endfunction

  // One-second increment with cascaded carry, 59:59 rolls to 00:00
  function automatic bcd_time_t time_inc(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_units != 4'd9) r.sec_units = t.sec_units + 4'd1;
    else begin
      r.sec_units = 4'd0;
      if (t.sec_tens != 4'd5) r.sec_tens = t.sec_tens + 4'd1;
      else begin
        r.sec_tens = 4'd0;
        if (t.min_units != 4'd9) r.min_units = t.min_units + 4'd1;
        else begin
          r.min_units = 4'd0;
          r.min_tens  = (t.min_tens == 4'd5) ? 4'd0 : t.min_tens + 4'd1;
        end
      end
    end
    return r;
  endfunction

  // One-second decrement with cascaded borrow, 00:00 rolls to 59:59
  function automatic bcd_time_t time_dec(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_units != 4'd0) r.sec_units = t.sec_units - 4'd1;
    else begin
      r.sec_units = 4'd9;
      if (t.sec_tens != 4'd0) r.sec_tens = t.sec_tens - 4'd1;
      else begin
        r.sec_tens = 4'd5;
        if (t.min_units != 4'd0) r.min_units = t.min_units - 4'd1;
        else begin
          r.min_units = 4'd9;
          r.min_tens  = (t.min_tens == 4'd0) ? 4'd5 : t.min_tens - 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex digit to seven-segment pattern, optionally inverted for active-high
// displays.
module seg7_decoder
  import stopwatch_ctrl_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit_i,
  output logic [0:6] seg_o
);

  // table lookup, polarity chosen at elaboration
  assign seg_o = SEG_ACTIVE_LOW ? SEG7_LUT[digit_i] : ~SEG7_LUT[digit_i];

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch / countdown timer: key synchronisers, run/pause FSM, subtick
// divider, BCD time counter with lap freeze and seven-segment outputs.
//
// state | meaning
// IDLE  | time loaded (00:00 or preset), waiting for start
// RUN   | subtick counting, time steps once per DIV cycles
// PAUSE | subtick and time held, start resumes
// DONE  | countdown reached 00:00, only clear leaves
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int TICK_HZ        = 1,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_clear_n,
  input  logic       key_lap_n,
  input  logic       mode_down,
  input  logic [5:0] preset_min,
  input  logic [5:0] preset_sec,
  output logic [0:6] HEX0,
  output logic [0:6] HEX1,
  output logic [0:6] HEX2,
  output logic [0:6] HEX3,
  output logic       running,
  output logic       done,
  output logic       wrap,
  output logic       lap_active
);

  localparam int DIV   = CLK_FREQ / TICK_HZ;
  localparam int SUB_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(DIV - 1);

  logic [2:0]       key_n;
  logic [2:0]       sync1_q;
  logic [2:0]       sync2_q;
  logic [2:0]       prev_q;
  logic [2:0]       key_fall;
  logic             start_ev;
  logic             clear_ev;
  logic             lap_ev;

  sw_state_e        state_q;
  logic [SUB_W-1:0] subtick_q;
  bcd_time_t        time_q;
  bcd_time_t        lap_time_q;
  bcd_time_t        time_next_d;
  bcd_time_t        preset_time;
  bcd_time_t        disp_time;
  logic             mode_q;
  logic             lap_q;
  logic             running_q;
  logic             done_q;
  logic             wrap_q;
  logic             tick;
  logic             step_zero;

  assign key_n = {key_lap_n, key_clear_n, key_start_n};

  // two-flop synchronisers plus one delay stage for falling-edge detect;
  // all released (1) in reset so leaving reset never looks like a press
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign key_fall = prev_q & ~sync2_q;
  assign clear_ev = key_fall[1];
  assign start_ev = key_fall[0] & ~clear_ev;
  assign lap_ev   = key_fall[2] & ~clear_ev;

  assign tick        = (state_q == ST_RUN) && (subtick_q == SUB_LAST);
  assign time_next_d = mode_q ? time_dec(time_q) : time_inc(time_q);
  assign step_zero   = (time_next_d == '0);
  assign preset_time = {bin_to_bcd(preset_min), bin_to_bcd(preset_sec)};

  // control FSM, subtick divider, time counter, lap capture and flags
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      subtick_q  <= '0;
      time_q     <= '0;
      lap_time_q <= '0;
      mode_q     <= mode_down;
      lap_q      <= 1'b0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (clear_ev) begin
        state_q   <= ST_IDLE;
        subtick_q <= '0;
        lap_q     <= 1'b0;
        mode_q    <= mode_down;
        time_q    <= mode_down ? preset_time : '0;
        running_q <= 1'b0;
      end else begin
        if (lap_ev && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
          lap_q <= ~lap_q;
          if (!lap_q) lap_time_q <= time_q;
        end
        case (state_q)
          ST_IDLE: begin
            if (start_ev) begin
              if (mode_q && time_q == '0) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q   <= ST_RUN;
                subtick_q <= '0;
                running_q <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            subtick_q <= tick ? '0 : subtick_q + 1'b1;
            if (tick) time_q <= time_next_d;
            if (tick && !mode_q && step_zero) wrap_q <= 1'b1;
            // reaching zero takes priority over a pause in the same cycle
            if (tick && mode_q && step_zero) begin
              state_q   <= ST_DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else if (start_ev) begin
              state_q   <= ST_PAUSE;
              running_q <= 1'b0;
            end
          end
          ST_PAUSE: begin
            if (start_ev) begin
              state_q   <= ST_RUN;
              running_q <= 1'b1;
            end
          end
          ST_DONE: begin
          end
        endcase
      end
    end
  end

  assign disp_time  = lap_q ? lap_time_q : time_q;
  assign running    = running_q;
  assign done       = done_q;
  assign wrap       = wrap_q;
  assign lap_active = lap_q;

  seg7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex0 (
    .digit_i(disp_time.sec_units), .seg_o(HEX0));
  seg7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex1 (
    .digit_i(disp_time.sec_tens), .seg_o(HEX1));
  seg7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex2 (
    .digit_i(disp_time.min_units), .seg_o(HEX2));
  seg7_decoder #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_hex3 (
    .digit_i(disp_time.min_tens), .seg_o(HEX3));

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DIV = 4. A seconds-based reference
// model predicts outputs per cycle; a monitor compares them as they appear.
module tb_stopwatch_ctrl;

  localparam int DIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  localparam logic [0:6] SEG_TAB [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  typedef struct {
    int          cyc;
    logic [31:0] vec;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_start_n, key_clear_n, key_lap_n;
  logic       mode_down;
  logic [5:0] preset_min, preset_sec;
  logic [0:6] HEX0, HEX1, HEX2, HEX3;
  logic       running, done, wrap, lap_active;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // reference model state: time held as plain seconds
  int          m_state, m_secs, m_lap_secs, m_sub;
  bit          m_mode, m_lap, m_done, m_wrap;
  bit          hist [3][4];
  logic [31:0] m_prev = 'x;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stopwatch_ctrl #(.CLK_FREQ(4), .TICK_HZ(1), .SEG_ACTIVE_LOW(1'b1)) dut (
    .CLOCK_50(clk), .reset(reset), .key_start_n(key_start_n),
    .key_clear_n(key_clear_n), .key_lap_n(key_lap_n), .mode_down(mode_down),
    .preset_min(preset_min), .preset_sec(preset_sec),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3),
    .running(running), .done(done), .wrap(wrap), .lap_active(lap_active));

  function automatic logic [27:0] hex_of(input int s);
    int mm, ss;
    mm = s / 60;
    ss = s % 60;
    return {SEG_TAB[mm / 10], SEG_TAB[mm % 10], SEG_TAB[ss / 10], SEG_TAB[ss % 10]};
  endfunction

  // Advance the model across the coming clock edge using current inputs.
  // A key level needs two cycles to be seen; a press is a falling seen level.
  task automatic model_step(output logic [31:0] vec);
    bit cur [3];
    bit ev [3];
    bit tick;
    int pm, ps;
    cur[0] = key_start_n;
    cur[1] = key_clear_n;
    cur[2] = key_lap_n;
    if (reset) begin
      for (int k = 0; k < 3; k++)
        for (int j = 0; j < 4; j++) hist[k][j] = 1'b1;
      m_state = M_IDLE; m_secs = 0; m_lap_secs = 0; m_sub = 0;
      m_mode = mode_down; m_lap = 0; m_done = 0; m_wrap = 0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        hist[k][3] = hist[k][2];
        hist[k][2] = hist[k][1];
        hist[k][1] = hist[k][0];
        hist[k][0] = cur[k];
        ev[k] = !hist[k][2] && hist[k][3];
      end
      m_done = 0;
      m_wrap = 0;
      if (ev[1]) begin
        pm = (preset_min > 59) ? 59 : int'(preset_min);
        ps = (preset_sec > 59) ? 59 : int'(preset_sec);
        m_state = M_IDLE; m_sub = 0; m_lap = 0; m_mode = mode_down;
        m_secs = mode_down ? pm * 60 + ps : 0;
      end else begin
        if (ev[2] && (m_state == M_RUN || m_state == M_PAUSE)) begin
          if (!m_lap) m_lap_secs = m_secs;
          m_lap = !m_lap;
        end
        tick = (m_state == M_RUN) && (m_sub == DIV - 1);
        case (m_state)
          M_IDLE:
            if (ev[0]) begin
              if (m_mode && m_secs == 0) begin m_state = M_DONE; m_done = 1; end
              else begin m_state = M_RUN; m_sub = 0; end
            end
          M_RUN: begin
            m_sub = (m_sub + 1) % DIV;
            if (tick && m_mode) begin
              m_secs = m_secs - 1;
              if (m_secs == 0) begin m_state = M_DONE; m_done = 1; end
            end else if (tick) begin
              m_secs = (m_secs + 1) % 3600;
              if (m_secs == 0) m_wrap = 1;
            end
            if (ev[0] && m_state == M_RUN) m_state = M_PAUSE;
          end
          M_PAUSE: if (ev[0]) m_state = M_RUN;
          default: ;
        endcase
      end
    end
    vec = {hex_of(m_lap ? m_lap_secs : m_secs), m_state == M_RUN, m_done, m_wrap, m_lap};
  endtask

  // predict the edge ahead, queue it if outputs change (or on request)
  task automatic step(input bit chk);
    exp_t        e;
    logic [31:0] v;
    model_step(v);
    if (chk || v !== m_prev) begin
      e.cyc = cyc + 1;
      e.vec = v;
      sb.push_back(e);
    end
    m_prev = v;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0);
  endtask

  task automatic set_key(input int k, input logic lvl);
    case (k)
      0: key_start_n = lvl;
      1: key_clear_n = lvl;
      default: key_lap_n = lvl;
    endcase
  endtask

  task automatic press(input int k);
    set_key(k, 1'b0);
    run(3);
    set_key(k, 1'b1);
    run(3);
  endtask

  // monitor: compare whenever the DUT outputs change or a prediction falls due
  initial begin
    logic [31:0] prev, vec;
    exp_t        e;
    bit          changed;
    prev = 'x;
    forever begin
      @(posedge clk);
      #1;
      vec = {HEX3, HEX2, HEX1, HEX0, running, done, wrap, lap_active};
      changed = (vec !== prev);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_sample cyc=%0d required=%h", e.cyc, e.vec);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        checks++;
        if (vec !== e.vec) begin
          errors++;
          $display("FAIL outputs cyc=%0d got=%h required=%h", cyc, vec, e.vec);
        end
      end else if (changed) begin
        checks++;
        errors++;
        $display("FAIL unexpected_change cyc=%0d got=%h required=%h", cyc, vec, prev);
      end
      prev = vec;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    key_start_n = 1'b1; key_clear_n = 1'b1; key_lap_n = 1'b1;
    mode_down = 1'b0; preset_min = 6'd0; preset_sec = 6'd0;
    step(1'b1);
    step(1'b0);
    reset = 1'b0;
    step(1'b1);

    // up count: 01:00 after 240 cycles, then through 59:59 -> 00:00 wrap
    press(0);
    run(234);
    step(1'b1);
    run(DIV * 3600);
    step(1'b1);

    // countdown from 00:03 to done, later starts ignored
    mode_down = 1'b1; preset_min = 6'd0; preset_sec = 6'd3;
    press(1);
    press(0);
    run(20);
    press(0);
    press(0);
    step(1'b1);

    // pause and resume keep the subtick phase
    mode_down = 1'b0;
    press(1);
    press(0);
    run(2);
    press(0);
    run(20);
    press(0);
    run(10);
    step(1'b1);

    // lap freeze while counting continues
    press(1);
    press(0);
    run(14);
    press(2);
    run(12);
    step(1'b1);
    press(2);
    run(4);
    step(1'b1);

    // clear and start together while running; preset clamping
    mode_down = 1'b1; preset_min = 6'd0; preset_sec = 6'd63;
    key_start_n = 1'b0; key_clear_n = 1'b0;
    run(3);
    key_start_n = 1'b1; key_clear_n = 1'b1;
    run(3);
    step(1'b1);
    preset_min = 6'd63; preset_sec = 6'd59;
    press(1);
    step(1'b1);
    press(0);
    run(40);

    // reset with countdown mode leaves 00:00, start goes straight to done
    reset = 1'b1;
    run(2);
    reset = 1'b0;
    run(2);
    press(0);
    run(4);
    step(1'b1);

    // randomized key activity, mode/preset changes and occasional reset
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 5) == 0) key_start_n = ~key_start_n;
      if ($urandom_range(0, 39) == 0) key_clear_n = ~key_clear_n;
      if ($urandom_range(0, 9) == 0) key_lap_n = ~key_lap_n;
      if ($urandom_range(0, 199) == 0) begin
        mode_down  = 1'($urandom_range(0, 1));
        preset_min = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
        preset_sec = 6'($urandom_range(0, 63));
      end
      reset = ($urandom_range(0, 599) == 0);
      step(1'b0);
    end
    reset = 1'b0;
    run(10);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d pending required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
